// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: ctrl bit
// positions, ctrl width and the request FSM state encoding.
package mem_stage_pkg;

  localparam int CTRL_W = 6;

  // Ctrl bus layout, MSB first: {alu_src_op, branch, mem_read, mem_write, mem2reg, reg_write}
  localparam int CTRL_ALU_SRC   = 5;
  localparam int CTRL_BRANCH    = 4;
  localparam int CTRL_MEM_READ  = 3;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_MEM2REG   = 1;
  localparam int CTRL_REG_WRITE = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } ms_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-RAM request/acknowledge bus between the memory stage (master)
// and the data memory (slave). The request and its address/data stay
// stable from data_req rising until data_ack is seen.
interface mem_stage_if #(
  parameter int DATA_W = 32
);
  logic              data_req;
  logic              data_we;
  logic [DATA_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_ack;

  modport master (
    output data_req,
    output data_we,
    output data_addr,
    output data_wdata,
    input  data_rdata,
    input  data_ack
  );

  modport slave (
    input  data_req,
    input  data_we,
    input  data_addr,
    input  data_wdata,
    output data_rdata,
    output data_ack
  );
endinterface

// File: rtl/mem_req_fsm.sv
// Request sequencer for the memory stage: tracks IDLE/ACCESS/HOLD,
// raises the request while in ACCESS and keeps the returned read data.
module mem_req_fsm #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,   // a memory op is captured this cycle
  input  logic              leave_i,   // current instruction moves to write-back
  input  logic              ack_i,
  input  logic [DATA_W-1:0] rdata_i,
  output mem_stage_pkg::ms_state_e state_o,
  output logic              req_o,
  output logic [DATA_W-1:0] rdata_o
);
  import mem_stage_pkg::*;

  ms_state_e         state_q, state_d;
  logic [DATA_W-1:0] rdata_q;

  // State register; reset abandons any outstanding access at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: ack is only honoured while a request is actually up
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = ACCESS;
      ACCESS:  if (ack_i)   state_d = HOLD;
      HOLD: begin
        if (leave_i) state_d = start_i ? ACCESS : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data captured on ack and held through any write-back stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          rdata_q <= '0;
    else if (state_q == ACCESS && ack_i) rdata_q <= rdata_i;
  end

  assign state_o = state_q;
  assign req_o   = (state_q == ACCESS);
  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between execute and write-back.
// Latches execute results, performs loads/stores over the req/ack data
// bus, resolves beq and presents write-back data.
// Optional: define MS_MISALIGN_CHK_EN to flag word-misaligned memory ops
// (no access issued, reg_write suppressed, ms_misalign port present).
module mem_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              es_valid,
  output logic              ms_allowin,
  input  logic [CTRL_W-1:0] es_ctrl,
  input  logic [4:0]        es_rd,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              zero,
  input  logic [DATA_W-1:0] nx_pc,
  input  logic              ws_allowin,
  output logic              ms_valid,
  output logic [CTRL_W-1:0] ms_ctrl,
  output logic [4:0]        ms_rd,
  output logic [DATA_W-1:0] ms_wb_data,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  mem_stage_if.master       mem_if
`ifdef MS_MISALIGN_CHK_EN
  ,
  output logic              ms_misalign
`endif
);
  import mem_stage_pkg::*;

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] wdata_q;
  logic              zero_q;
  logic [DATA_W-1:0] nxpc_q;

  ms_state_e         state;
  logic              req;
  logic [DATA_W-1:0] rdata;

  logic              ms_ready_go;
  logic              capture;
  logic              leave;
  logic              es_mem_op;
  logic              start;

  assign es_mem_op = es_ctrl[CTRL_MEM_READ] | es_ctrl[CTRL_MEM_WRITE];

  // Only HOLD (access done) and IDLE (non-memory or rejected op) may hand off
  assign ms_ready_go = (state == IDLE) || (state == HOLD);
  assign ms_allowin  = !valid_q || (ms_ready_go && ws_allowin);
  assign capture     = es_valid && ms_allowin;
  assign leave       = valid_q && ms_ready_go && ws_allowin;

`ifdef MS_MISALIGN_CHK_EN
  logic es_misalign;
  logic misalign_q;

  assign es_misalign = es_mem_op && (alu_result[1:0] != 2'b00);
  assign start       = capture && es_mem_op && !es_misalign;

  // Misalign flag travels with the instruction it belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          misalign_q <= 1'b0;
    else if (ms_allowin) misalign_q <= es_valid && es_misalign;
  end

  assign ms_misalign = misalign_q;
  assign ms_ctrl     = {ctrl_q[CTRL_W-1:1], ctrl_q[CTRL_REG_WRITE] & ~misalign_q};
`else
  assign start   = capture && es_mem_op;
  assign ms_ctrl = ctrl_q;
`endif

  // Stage valid follows execute whenever this stage can accept
  always_comb begin
    valid_d = valid_q;
    if (ms_allowin) valid_d = es_valid;
  end

  // Valid flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  // Latch execute results only when an instruction is actually accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
      wdata_q <= '0;
      zero_q  <= 1'b0;
      nxpc_q  <= '0;
    end else if (capture) begin
      ctrl_q  <= es_ctrl;
      rd_q    <= es_rd;
      alu_q   <= alu_result;
      wdata_q <= wr_data;
      zero_q  <= zero;
      nxpc_q  <= nx_pc;
    end
  end

  mem_req_fsm #(
    .DATA_W (DATA_W)
  ) u_req_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .leave_i (leave),
    .ack_i   (mem_if.data_ack),
    .rdata_i (mem_if.data_rdata),
    .state_o (state),
    .req_o   (req),
    .rdata_o (rdata)
  );

  // Address/data come straight from latched state, so they are stable for
  // the whole request; a read+write combination is issued as a write.
  assign mem_if.data_req   = req;
  assign mem_if.data_we    = req && ctrl_q[CTRL_MEM_WRITE];
  assign mem_if.data_addr  = alu_q;
  assign mem_if.data_wdata = wdata_q;

  assign ms_valid   = valid_q;
  assign ms_rd      = rd_q;
  assign ms_wb_data = ctrl_q[CTRL_MEM2REG] ? rdata : alu_q;
  assign br_taken   = valid_q && ctrl_q[CTRL_BRANCH] && zero_q;
  assign br_target  = nxpc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a hand-driven memory.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        es_valid;
  logic        ms_allowin;
  logic [5:0]  es_ctrl;
  logic [4:0]  es_rd;
  logic [31:0] alu_result;
  logic [31:0] wr_data;
  logic        zero;
  logic [31:0] nx_pc;
  logic        ws_allowin;
  logic        ms_valid;
  logic [5:0]  ms_ctrl;
  logic [4:0]  ms_rd;
  logic [31:0] ms_wb_data;
  logic        br_taken;
  logic [31:0] br_target;
`ifdef MS_MISALIGN_CHK_EN
  logic        ms_misalign;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mem_stage_if #(.DATA_W(32)) mem_if ();

  mem_stage #(.DATA_W(32), .CTRL_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .es_valid   (es_valid),
    .ms_allowin (ms_allowin),
    .es_ctrl    (es_ctrl),
    .es_rd      (es_rd),
    .alu_result (alu_result),
    .wr_data    (wr_data),
    .zero       (zero),
    .nx_pc      (nx_pc),
    .ws_allowin (ws_allowin),
    .ms_valid   (ms_valid),
    .ms_ctrl    (ms_ctrl),
    .ms_rd      (ms_rd),
    .ms_wb_data (ms_wb_data),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .mem_if     (mem_if.master)
`ifdef MS_MISALIGN_CHK_EN
    ,
    .ms_misalign(ms_misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_es(input logic v, input logic [5:0] c, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] wd,
                          input logic z, input logic [31:0] pc);
    es_valid   = v;
    es_ctrl    = c;
    es_rd      = rd;
    alu_result = alu;
    wr_data    = wd;
    zero       = z;
    nx_pc      = pc;
  endtask

  initial begin
    rst_n = 1'b0;
    ws_allowin = 1'b1;
    mem_if.data_ack   = 1'b0;
    mem_if.data_rdata = 32'h0;
    drive_es(1'b0, 6'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    #12;
    chk("rst_valid",    32'(ms_valid), 32'd0);
    chk("rst_req",      32'(mem_if.data_req), 32'd0);
    chk("rst_we",       32'(mem_if.data_we), 32'd0);
    chk("rst_wb",       ms_wb_data, 32'h0);
    chk("rst_addr",     mem_if.data_addr, 32'h0);
    chk("rst_br",       32'(br_taken), 32'd0);
    chk("rst_allowin",  32'(ms_allowin), 32'd1);
    rst_n = 1'b1;
    tick;

    // Non-memory op: one-cycle latency, no request
    drive_es(1'b1, 6'b000001, 5'd3, 32'h10, 32'h0, 1'b0, 32'h0);
    tick;
    es_valid = 1'b0;
    #1;
    chk("alu_valid", 32'(ms_valid), 32'd1);
    chk("alu_wb",    ms_wb_data, 32'h10);
    chk("alu_req",   32'(mem_if.data_req), 32'd0);
    chk("alu_rd",    32'(ms_rd), 32'd3);
    chk("alu_ctrl",  32'(ms_ctrl), 32'h01);
    tick;
    chk("alu_drain", 32'(ms_valid), 32'd0);

    // Load with ack on the third request cycle
    drive_es(1'b1, 6'b101011, 5'd5, 32'h100, 32'h0, 1'b0, 32'h0);
    tick;
    es_valid = 1'b0;
    #1;
    chk("ld_req1",   32'(mem_if.data_req), 32'd1);
    chk("ld_we",     32'(mem_if.data_we), 32'd0);
    chk("ld_addr",   mem_if.data_addr, 32'h100);
    chk("ld_allow1", 32'(ms_allowin), 32'd0);
    tick;
    chk("ld_req2",   32'(mem_if.data_req), 32'd1);
    chk("ld_allow2", 32'(ms_allowin), 32'd0);
    tick;
    mem_if.data_ack   = 1'b1;
    mem_if.data_rdata = 32'hDEADBEEF;
    #1;
    chk("ld_req3",   32'(mem_if.data_req), 32'd1);
    chk("ld_allow3", 32'(ms_allowin), 32'd0);
    tick;
    mem_if.data_ack = 1'b0;
    #1;
    chk("ld_req_drop", 32'(mem_if.data_req), 32'd0);
    chk("ld_valid",    32'(ms_valid), 32'd1);
    chk("ld_wb",       ms_wb_data, 32'hDEADBEEF);
    chk("ld_allow_h",  32'(ms_allowin), 32'd1);
    tick;
    chk("ld_drain", 32'(ms_valid), 32'd0);

    // Store with zero-wait ack
    drive_es(1'b1, 6'b100100, 5'd7, 32'h20, 32'h55, 1'b0, 32'h0);
    tick;
    es_valid = 1'b0;
    mem_if.data_ack = 1'b1;
    #1;
    chk("st_req",   32'(mem_if.data_req), 32'd1);
    chk("st_we",    32'(mem_if.data_we), 32'd1);
    chk("st_wdata", mem_if.data_wdata, 32'h55);
    chk("st_addr",  mem_if.data_addr, 32'h20);
    tick;
    mem_if.data_ack = 1'b0;
    #1;
    chk("st_req_drop", 32'(mem_if.data_req), 32'd0);
    chk("st_we_drop",  32'(mem_if.data_we), 32'd0);
    chk("st_valid",    32'(ms_valid), 32'd1);
    chk("st_regwr",    32'(ms_ctrl[0]), 32'd0);
    tick;

    // beq taken, then not taken
    drive_es(1'b1, 6'b010000, 5'd0, 32'h0, 32'h0, 1'b1, 32'h40);
    tick;
    es_valid = 1'b0;
    #1;
    chk("beq_taken",  32'(br_taken), 32'd1);
    chk("beq_target", br_target, 32'h40);
    chk("beq_req",    32'(mem_if.data_req), 32'd0);
    tick;
    chk("beq_drain",  32'(br_taken), 32'd0);
    drive_es(1'b1, 6'b010000, 5'd0, 32'h0, 32'h0, 1'b0, 32'h80);
    tick;
    es_valid = 1'b0;
    #1;
    chk("bne_taken",  32'(br_taken), 32'd0);
    chk("bne_target", br_target, 32'h80);
    chk("bne_valid",  32'(ms_valid), 32'd1);
    tick;

    // Load acked under write-back backpressure
    drive_es(1'b1, 6'b101011, 5'd9, 32'h200, 32'h0, 1'b0, 32'h0);
    tick;
    es_valid   = 1'b0;
    ws_allowin = 1'b0;
    mem_if.data_ack   = 1'b1;
    mem_if.data_rdata = 32'hCAFEF00D;
    tick;
    mem_if.data_ack   = 1'b0;
    mem_if.data_rdata = 32'h0BADF00D;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bp_valid%0d", i), 32'(ms_valid), 32'd1);
      chk($sformatf("bp_wb%0d", i),    ms_wb_data, 32'hCAFEF00D);
      chk($sformatf("bp_req%0d", i),   32'(mem_if.data_req), 32'd0);
      chk($sformatf("bp_allow%0d", i), 32'(ms_allowin), 32'd0);
      tick;
    end

    // Release backpressure while a new load is waiting: straight to ACCESS
    ws_allowin = 1'b1;
    drive_es(1'b1, 6'b101011, 5'd10, 32'h300, 32'h0, 1'b0, 32'h0);
    #1;
    chk("b2b_allow", 32'(ms_allowin), 32'd1);
    tick;
    es_valid = 1'b0;
    #1;
    chk("b2b_req",   32'(mem_if.data_req), 32'd1);
    chk("b2b_addr",  mem_if.data_addr, 32'h300);
    chk("b2b_valid", 32'(ms_valid), 32'd1);
    chk("b2b_rd",    32'(ms_rd), 32'd10);
    tick;

`ifdef MS_MISALIGN_CHK_EN
    mem_if.data_ack = 1'b1;
    tick;
    mem_if.data_ack = 1'b0;
    tick;
    drive_es(1'b1, 6'b101011, 5'd4, 32'h102, 32'h0, 1'b0, 32'h0);
    tick;
    es_valid = 1'b0;
    #1;
    chk("mis_flag",  32'(ms_misalign), 32'd1);
    chk("mis_req",   32'(mem_if.data_req), 32'd0);
    chk("mis_regwr", 32'(ms_ctrl[0]), 32'd0);
    chk("mis_allow", 32'(ms_allowin), 32'd1);
    tick;
    drive_es(1'b1, 6'b101011, 5'd10, 32'h300, 32'h0, 1'b0, 32'h0);
    tick;
    es_valid = 1'b0;
    tick;
`endif

    // Asynchronous reset in the middle of an access
    #2;
    chk("pre_rst_req", 32'(mem_if.data_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_req",   32'(mem_if.data_req), 32'd0);
    chk("arst_valid", 32'(ms_valid), 32'd0);
    chk("arst_addr",  mem_if.data_addr, 32'h0);
    chk("arst_wb",    ms_wb_data, 32'h0);
    chk("arst_rd",    32'(ms_rd), 32'd0);
    #1;
    rst_n = 1'b1;
    mem_if.data_ack   = 1'b1;
    mem_if.data_rdata = 32'h12345678;
    tick;
    mem_if.data_ack = 1'b0;
    #1;
    chk("late_ack_valid", 32'(ms_valid), 32'd0);
    chk("late_ack_req",   32'(mem_if.data_req), 32'd0);
    chk("late_ack_wb",    ms_wb_data, 32'h0);
    tick;
    chk("late_ack_valid2", 32'(ms_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
